// File: rtl/column_stream_pkg.sv
`default_nettype none
// ============================================================================
// column_stream_pkg : shared record type, FSM states and register map
// Rev 1.0
// ============================================================================
package column_stream_pkg;

    localparam int NUM_COLS_DEFAULT = 640;

    localparam logic [3:0] ADDR_SYNC = 4'd0;
    localparam logic [3:0] ADDR_COL  = 4'd1;

    typedef struct packed {
        logic        sof;
        logic [9:0]  tex;
        logic [15:0] height;
        logic [15:0] top;
        logic [15:0] sf;
    } col_rec_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SYNC     = 3'd1,
        W_TEX    = 3'd2,
        W_HEIGHT = 3'd3,
        W_TOP    = 3'd4,
        W_SF     = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/column_stream_writer_if.sv
`default_nettype none
// ============================================================================
// column_stream_writer_if : record stream in, Avalon write bus and status out
// Rev 1.0
// ============================================================================
interface column_stream_writer_if;

    logic        in_valid;
    logic        in_ready;
    logic        in_sof;
    logic [9:0]  in_tex;
    logic [15:0] in_height;
    logic [15:0] in_top;
    logic [15:0] in_sf;

    logic        avm_chipselect;
    logic        avm_write;
    logic [3:0]  avm_address;
    logic [15:0] avm_writedata;

    logic        frame_done;
    logic        seq_err;

    // Record producer side.
    modport master (
        output in_valid, in_sof, in_tex, in_height, in_top, in_sf,
        input  in_ready, avm_chipselect, avm_write, avm_address, avm_writedata,
        input  frame_done, seq_err
    );

    // Writer side.
    modport slave (
        input  in_valid, in_sof, in_tex, in_height, in_top, in_sf,
        output in_ready, avm_chipselect, avm_write, avm_address, avm_writedata,
        output frame_done, seq_err
    );

endinterface
`default_nettype wire

// File: rtl/column_fifo.sv
`default_nettype none
// ============================================================================
// column_fifo : synchronous record FIFO exposing the head and the entry behind it
// Rev 1.0
// ============================================================================
module column_fifo #(
    parameter int  DEPTH = 4,
    parameter type REC_T = logic
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic push,
    input  wire REC_T push_data,
    input  wire logic pop,
    output REC_T      head,
    output REC_T      next,
    output logic      full,
    output logic      empty,
    output logic      has_two
);

    localparam int                  c_ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ADDR_W-1:0] c_PTR_ONE  = c_ADDR_W'(1);
    localparam logic [c_ADDR_W:0]   c_CNT_ONE  = (c_ADDR_W+1)'(1);
    localparam logic [c_ADDR_W:0]   c_CNT_FULL = (c_ADDR_W+1)'(DEPTH);

    REC_T                r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_rd;
    logic [c_ADDR_W-1:0] r_wr;
    logic [c_ADDR_W:0]   r_count;
    logic                w_push;
    logic                w_pop;

    // A push is refused whenever full, even if a pop happens in the same cycle.
    assign full    = (r_count == c_CNT_FULL);
    assign empty   = (r_count == '0);
    assign has_two = (r_count > c_CNT_ONE);
    assign w_push  = push && !full;
    assign w_pop   = pop && !empty;

    assign head = r_mem[r_rd];
    assign next = r_mem[r_rd + c_PTR_ONE];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd <= r_rd + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/column_stream_writer.sv
`default_nettype none
// ============================================================================
// column_stream_writer : buffers column records and replays each one as a
// burst of Avalon writes to the column decoder.   Rev 1.0
// ============================================================================
module column_stream_writer
    import column_stream_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_COLS   = NUM_COLS_DEFAULT
) (
    input  wire logic             clk,
    input  wire logic             reset,
    column_stream_writer_if.slave bus
);

    localparam logic [9:0] c_LAST_COL = 10'(NUM_COLS - 1);

    col_rec_t    w_in_rec;
    col_rec_t    w_head;
    col_rec_t    w_next;
    logic        w_full;
    logic        w_empty;
    logic        w_has_two;
    logic        w_pop;
    logic [9:0]  w_cnt_next;
    logic        w_cont;
    logic        w_unused;

    state_t      r_state;
    logic [9:0]  r_col_cnt;
    logic        r_cs;
    logic        r_wr;
    logic [3:0]  r_addr;
    logic [15:0] r_wdata;
    logic        r_frame_done;
    logic        r_seq_err;

    assign w_in_rec = '{sof:    bus.in_sof,
                        tex:    bus.in_tex,
                        height: bus.in_height,
                        top:    bus.in_top,
                        sf:     bus.in_sf};

    column_fifo #(
        .DEPTH (FIFO_DEPTH),
        .REC_T (col_rec_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (bus.in_valid),
        .push_data (w_in_rec),
        .pop       (w_pop),
        .head      (w_head),
        .next      (w_next),
        .full      (w_full),
        .empty     (w_empty),
        .has_two   (w_has_two)
    );

    // Only the framing and texture fields of the look-ahead entry matter.
    assign w_unused = ^{w_next.height, w_next.top, w_next.sf};

    assign w_cnt_next = (r_col_cnt == c_LAST_COL) ? 10'd0 : r_col_cnt + 10'd1;
    assign w_cont     = w_has_two && (w_cnt_next != 10'd0) && !w_next.sof;

    // Pop at the end of the last write of a column, or to drop an orphan record.
    assign w_pop = (r_state == W_SF) ||
                   ((r_state == IDLE) && !w_empty && (r_col_cnt == 10'd0) && !w_head.sof);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_col_cnt    <= '0;
            r_cs         <= 1'b0;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_frame_done <= 1'b0;
            r_seq_err    <= 1'b0;
        end else begin
            r_cs         <= 1'b0;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        if (w_head.sof) begin
                            if (r_col_cnt != 10'd0) begin
                                r_seq_err <= 1'b1;
                                r_col_cnt <= '0;
                            end
                            r_state <= SYNC;
                            r_cs    <= 1'b1;
                            r_wr    <= 1'b1;
                            r_addr  <= ADDR_SYNC;
                            r_wdata <= 16'd0;
                        end else if (r_col_cnt != 10'd0) begin
                            r_state <= W_TEX;
                            r_cs    <= 1'b1;
                            r_wr    <= 1'b1;
                            r_addr  <= ADDR_COL;
                            r_wdata <= {6'b0, w_head.tex};
                        end else begin
                            r_seq_err <= 1'b1;
                        end
                    end
                end
                SYNC: begin
                    r_state <= W_TEX;
                    r_cs    <= 1'b1;
                    r_wr    <= 1'b1;
                    r_addr  <= ADDR_COL;
                    r_wdata <= {6'b0, w_head.tex};
                end
                W_TEX: begin
                    r_state <= W_HEIGHT;
                    r_cs    <= 1'b1;
                    r_wr    <= 1'b1;
                    r_addr  <= ADDR_COL;
                    r_wdata <= w_head.height;
                end
                W_HEIGHT: begin
                    r_state <= W_TOP;
                    r_cs    <= 1'b1;
                    r_wr    <= 1'b1;
                    r_addr  <= ADDR_COL;
                    r_wdata <= w_head.top;
                end
                W_TOP: begin
                    r_state <= W_SF;
                    r_cs    <= 1'b1;
                    r_wr    <= 1'b1;
                    r_addr  <= ADDR_COL;
                    r_wdata <= w_head.sf;
                end
                W_SF: begin
                    r_col_cnt    <= w_cnt_next;
                    r_frame_done <= (r_col_cnt == c_LAST_COL);
                    // Chain straight into the next column when it is already queued.
                    if (w_cont) begin
                        r_state <= W_TEX;
                        r_cs    <= 1'b1;
                        r_wr    <= 1'b1;
                        r_addr  <= ADDR_COL;
                        r_wdata <= {6'b0, w_next.tex};
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready       = !w_full;
    assign bus.avm_chipselect = r_cs;
    assign bus.avm_write      = r_wr;
    assign bus.avm_address    = r_addr;
    assign bus.avm_writedata  = r_wdata;
    assign bus.frame_done     = r_frame_done;
    assign bus.seq_err        = r_seq_err;

endmodule
`default_nettype wire

// File: tb/tb_column_stream_writer.sv
`default_nettype none
// ============================================================================
// tb_column_stream_writer : random and directed record streams against a
// record-level model of the expected Avalon write sequence.   Rev 1.0
// ============================================================================
module tb_column_stream_writer;
    import column_stream_pkg::*;

    localparam int FIFO_DEPTH = 4;
    localparam int NUM_COLS   = 640;

    logic clk;
    logic reset;
    column_stream_writer_if bus ();

    column_stream_writer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .NUM_COLS   (NUM_COLS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [19:0] exp_q [$];
    int   m_cnt;
    logic m_err;
    int   exp_frames, obs_frames;
    int   wr_count, acc_cnt, acc_at_full;
    logic full_seen;
    int   cyc, first_wr_cyc, last_wr_cyc, done_cyc;
    logic [3:0] first_addr;
    logic stop_drive;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected writes derived directly from the framing rules, one record at a time.
    task automatic model_accept(input col_rec_t r);
        if (m_cnt == 0 && !r.sof) begin
            m_err = 1'b1;
        end else begin
            if (m_cnt != 0 && r.sof) begin
                m_err = 1'b1;
                m_cnt = 0;
            end
            if (m_cnt == 0) exp_q.push_back({ADDR_SYNC, 16'd0});
            exp_q.push_back({ADDR_COL, 6'd0, r.tex});
            exp_q.push_back({ADDR_COL, r.height});
            exp_q.push_back({ADDR_COL, r.top});
            exp_q.push_back({ADDR_COL, r.sf});
            m_cnt++;
            if (m_cnt == NUM_COLS) begin
                m_cnt = 0;
                exp_frames++;
            end
        end
    endtask

    always @(negedge clk) begin
        col_rec_t    r;
        logic [19:0] e;
        cyc++;
        if (reset) begin
            exp_q.delete();
            m_cnt = 0;
            m_err = 1'b0;
        end else begin
            if (bus.avm_write) begin
                if (wr_count == 0) begin
                    first_wr_cyc = cyc;
                    first_addr   = bus.avm_address;
                end
                last_wr_cyc = cyc;
                wr_count++;
                check("wr_cs", bus.avm_chipselect, 1'b1);
                check("wr_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", bus.avm_address, e[19:16]);
                    check("wr_data", bus.avm_writedata, e[15:0]);
                end
            end else begin
                check("idle_cs", bus.avm_chipselect, 1'b0);
            end
            if (bus.frame_done) begin
                obs_frames++;
                done_cyc = cyc;
            end
            if (!bus.in_ready && !full_seen) begin
                full_seen   = 1'b1;
                acc_at_full = acc_cnt;
            end
            if (bus.in_valid && bus.in_ready) begin
                acc_cnt++;
                r.sof = bus.in_sof;   r.tex = bus.in_tex;   r.height = bus.in_height;
                r.top = bus.in_top;   r.sf  = bus.in_sf;
                model_accept(r);
            end
        end
    end

    function automatic col_rec_t rand_rec(input logic sof);
        col_rec_t r;
        r.sof    = sof;
        r.tex    = 10'($urandom);
        r.height = 16'($urandom_range(1, 65535));
        r.top    = 16'($urandom);
        r.sf     = 16'($urandom);
        return r;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input col_rec_t r);
        int   n;
        logic acc;
        if (!stop_drive) begin
            bus.in_valid  = 1'b1;
            bus.in_sof    = r.sof;   bus.in_tex = r.tex;   bus.in_height = r.height;
            bus.in_top    = r.top;   bus.in_sf  = r.sf;
            n   = 0;
            acc = 1'b0;
            do begin
                @(negedge clk);
                acc = bus.in_ready;
                @(posedge clk);
                n++;
            end while (!acc && !stop_drive && n < 200);
            if (!stop_drive) check("send_accepted", acc, 1'b1);
            #1 bus.in_valid = 1'b0;
        end
    endtask

    task automatic gap(input int g);
        if (g > 0) begin
            repeat (g) @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic phase_start();
        wr_count   = 0;  acc_cnt    = 0;  full_seen  = 1'b0;  acc_at_full = 0;
        exp_frames = 0;  obs_frames = 0;  first_wr_cyc = 0;   last_wr_cyc = 0;
        done_cyc   = 0;  first_addr = 4'hF;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        col_rec_t r;
        cyc = 0;  m_cnt = 0;  m_err = 1'b0;  stop_drive = 1'b0;
        bus.in_valid = 1'b0;  bus.in_sof = 1'b0;  bus.in_tex = '0;
        bus.in_height = '0;   bus.in_top = '0;    bus.in_sf = '0;
        phase_start();
        reset = 1'b1;
        #2;
        check("rst_avm_wr", bus.avm_write, 1'b0);
        do_reset();

        check("rst_in_ready",   bus.in_ready, 1'b1);
        check("rst_avm_cs",     bus.avm_chipselect, 1'b0);
        check("rst_avm_addr",   bus.avm_address, 4'd0);
        check("rst_avm_data",   bus.avm_writedata, 16'd0);
        check("rst_frame_done", bus.frame_done, 1'b0);
        check("rst_seq_err",    bus.seq_err, 1'b0);

        // Orphan record after reset is dropped silently except for the error flag.
        phase_start();
        send(rand_rec(1'b0));
        gap(10);
        check("orphan_writes",  wr_count, 0);
        check("orphan_seq_err", bus.seq_err, 1'b1);
        do_reset();

        // First write one edge after the accepting edge.
        phase_start();
        send(rand_rec(1'b1));
        @(negedge clk);
        check("lat_t0_write", bus.avm_write, 1'b0);
        @(negedge clk);
        check("lat_t1_write", bus.avm_write, 1'b1);
        check("lat_t1_addr",  bus.avm_address, ADDR_SYNC);
        @(posedge clk); #1;
        drain();
        do_reset();

        // Back-to-back burst fills the FIFO.
        phase_start();
        send(rand_rec(1'b1));
        for (int i = 1; i < 8; i++) send(rand_rec(1'b0));
        drain();
        check("full_seen",   full_seen, 1'b1);
        check("acc_at_full", acc_at_full, FIFO_DEPTH);
        check("full_accepts", acc_cnt, 8);
        do_reset();

        // Complete frame of identical records.
        phase_start();
        r.tex = 10'h2C3;  r.height = 16'd100;  r.top = 16'hFFFB;  r.sf = 16'h140;
        for (int i = 0; i < NUM_COLS; i++) begin
            r.sof = (i == 0);
            send(r);
        end
        drain();
        check("frame_writes",   wr_count, 1 + 4 * NUM_COLS);
        check("frame_span",     last_wr_cyc - first_wr_cyc + 1, 1 + 4 * NUM_COLS);
        check("frame_first",    first_addr, ADDR_SYNC);
        check("frame_done_cnt", obs_frames, 1);
        check("frame_done_cyc", done_cyc, last_wr_cyc + 1);
        check("frame_seq_err",  bus.seq_err, 1'b0);

        // Sparse source: one record every 7th cycle.
        phase_start();
        for (int i = 0; i < 20; i++) begin
            send(rand_rec(i == 0));
            gap(6);
        end
        drain();
        check("gap_writes",  wr_count, 1 + 4 * 20);
        check("gap_seq_err", bus.seq_err, 1'b0);
        do_reset();

        // Early sof at column 300 restarts the frame count.
        phase_start();
        for (int i = 0; i < 300; i++) send(rand_rec(i == 0));
        send(rand_rec(1'b1));
        for (int i = 1; i < NUM_COLS - 1; i++) send(rand_rec(1'b0));
        drain();
        check("resync_seq_err", bus.seq_err, 1'b1);
        check("resync_no_done", obs_frames, 0);
        send(rand_rec(1'b0));
        drain();
        check("resync_done",    obs_frames, 1);
        check("resync_model",   obs_frames, exp_frames);
        do_reset();

        // Reset while column 10 is on its height write.
        phase_start();
        stop_drive = 1'b0;
        fork
            begin
                send(rand_rec(1'b1));
                for (int i = 1; i < 30; i++) send(rand_rec(1'b0));
            end
            begin
                int n;
                n = 0;
                do begin
                    @(negedge clk);
                    #1;
                    n++;
                end while (wr_count < 43 && n < 2000);
                check("midrst_reach",    wr_count, 43);
                check("midrst_pre_wr",   bus.avm_write, 1'b1);
                stop_drive = 1'b1;
                reset      = 1'b1;
                #1;
                check("midrst_cs",   bus.avm_chipselect, 1'b0);
                check("midrst_wr",   bus.avm_write, 1'b0);
                check("midrst_addr", bus.avm_address, 4'd0);
                check("midrst_data", bus.avm_writedata, 16'd0);
            end
        join
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        stop_drive = 1'b0;
        phase_start();
        send(rand_rec(1'b1));
        send(rand_rec(1'b0));
        drain();
        check("midrst_sync_first", first_addr, ADDR_SYNC);
        check("midrst_writes",     wr_count, 1 + 4 * 2);
        do_reset();

        // Random framing and source gaps.
        phase_start();
        for (int i = 0; i < 300; i++) begin
            send(rand_rec($urandom_range(0, 3) == 0));
            gap($urandom_range(0, 3));
        end
        drain();
        check("rand_frames",  obs_frames, exp_frames);
        check("rand_seq_err", bus.seq_err, m_err);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
